alsu_cmd_driver: RTL and testbench

//  Host-side driver for the ALSU. Accepts packed ALSU commands on a valid/ready

---
 rtl/alsu_cmd_driver_if.sv | 44 ++++
 rtl/alsu_cmd_driver.sv | 190 +++++++++++++++++++
 tb/tb_alsu_cmd_driver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_cmd_driver_if.sv
// Command/response streams, ALSU pin bundle and status between a sequencer and alsu_cmd_driver.
// slave = the driver side, master = the sequencer/ALSU side.
interface alsu_cmd_driver_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_data;

  logic [2:0]       alsu_A;
  logic [2:0]       alsu_B;
  logic [2:0]       alsu_opcode;
  logic             alsu_cin;
  logic             alsu_serial_in;
  logic             alsu_direction;
  logic             alsu_red_op_A;
  logic             alsu_red_op_B;
  logic             alsu_bypass_A;
  logic             alsu_bypass_B;
  logic [5:0]       alsu_out;
  logic [15:0]      alsu_leds;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_out;
  logic             rsp_invalid;
  logic             rsp_mismatch;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;

  modport slave (
    input  cmd_valid, cmd_data, alsu_out, alsu_leds, rsp_ready,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           rsp_valid, rsp_out, rsp_invalid, rsp_mismatch, busy, cmd_count
  );

  modport master (
    output cmd_valid, cmd_data, alsu_out, alsu_leds, rsp_ready,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           rsp_valid, rsp_out, rsp_invalid, rsp_mismatch, busy, cmd_count
  );
endinterface

// File: rtl/alsu_cmd_driver.sv
// Drives one ALSU command for a single cycle, waits LATENCY edges, returns out/leds as a response.
// Optional ALU reference check enabled by macro ALSU_DRV_CHECK_EN (otherwise rsp_mismatch is 0).
module alsu_cmd_driver #(
  parameter int    LATENCY        = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  alsu_cmd_driver_if.slave  bus
);

  localparam int CW = $clog2(LATENCY);

  // Reject configurations the ALSU itself cannot have.
  generate
    if (LATENCY < 3) begin : g_bad_latency
      $error("alsu_cmd_driver: LATENCY must be at least 3");
    end
    if (INPUT_PRIORITY != "A" && INPUT_PRIORITY != "B") begin : g_bad_priority
      $error("alsu_cmd_driver: INPUT_PRIORITY must be A or B");
    end
    if (FULL_ADDER != "ON" && FULL_ADDER != "OFF") begin : g_bad_adder
      $error("alsu_cmd_driver: FULL_ADDER must be ON or OFF");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [15:0]       r_pins;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [5:0]        r_rsp_out;
  logic              r_rsp_invalid;
  logic [CNT_W-1:0]  r_cmd_count;
  logic              w_leds_invalid;

`ifdef ALSU_DRV_CHECK_EN
  logic [5:0]        r_exp_out;
  logic              r_exp_inv;
  logic              r_rsp_mismatch;

  // Expected {invalid, out} for a command issued after idle cycles (prior ALSU out is 0).
  function automatic logic [6:0] f_ref(input logic [15:0] d);
    logic [2:0] a, b, op;
    logic       cin, sin, dir, ra, rb, ba, bb, inv;
    logic [5:0] o;
    a   = d[2:0];
    b   = d[5:3];
    op  = d[8:6];
    cin = d[9];
    sin = d[10];
    dir = d[11];
    ra  = d[12];
    rb  = d[13];
    ba  = d[14];
    bb  = d[15];
    inv = (op[2] & op[1]) | ((ra | rb) & (op[1] | op[2]));
    o   = 6'd0;
    if (ba && bb)       o = (INPUT_PRIORITY == "A") ? {3'b0, a} : {3'b0, b};
    else if (ba)        o = {3'b0, a};
    else if (bb)        o = {3'b0, b};
    else if (!inv) begin
      case (op)
        3'd0: begin
          if (ra && rb)  o = (INPUT_PRIORITY == "A") ? {5'b0, &a} : {5'b0, &b};
          else if (ra)   o = {5'b0, &a};
          else if (rb)   o = {5'b0, &b};
          else           o = {3'b0, a & b};
        end
        3'd1: begin
          if (ra && rb)  o = (INPUT_PRIORITY == "A") ? {5'b0, ^a} : {5'b0, ^b};
          else if (ra)   o = {5'b0, ^a};
          else if (rb)   o = {5'b0, ^b};
          else           o = {3'b0, a ^ b};
        end
        3'd2: o = (FULL_ADDER == "ON") ? ({3'b0, a} + {3'b0, b} + {5'b0, cin})
                                       : ({3'b0, a} + {3'b0, b});
        3'd3: o = {3'b0, a} * {3'b0, b};
        3'd4: o = dir ? {5'b0, sin} : {sin, 5'b0};
        default: o = 6'd0;
      endcase
    end
    return {inv, o};
  endfunction
`endif

  assign w_leds_invalid = (bus.alsu_leds == 16'hFFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pins        <= 16'h0000;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_out     <= 6'd0;
      r_rsp_invalid <= 1'b0;
      r_cmd_count   <= '0;
`ifdef ALSU_DRV_CHECK_EN
      r_exp_out      <= 6'd0;
      r_exp_inv      <= 1'b0;
      r_rsp_mismatch <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_pins      <= bus.cmd_data;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_DRIVE;
`ifdef ALSU_DRV_CHECK_EN
            {r_exp_inv, r_exp_out} <= f_ref(bus.cmd_data);
`endif
          end
        end
        // Pins go back to the idle pattern so the ALSU's shift history and leds return to 0.
        S_DRIVE: begin
          r_pins  <= 16'h0000;
          r_cnt   <= CW'(LATENCY - 2);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_out     <= bus.alsu_out;
            r_rsp_invalid <= w_leds_invalid;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
`ifdef ALSU_DRV_CHECK_EN
            r_rsp_mismatch <= (bus.alsu_out != r_exp_out) || (w_leds_invalid != r_exp_inv);
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_count <= r_cmd_count + CNT_W'(1);
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_pins      <= 16'h0000;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alsu_A         = r_pins[2:0];
  assign bus.alsu_B         = r_pins[5:3];
  assign bus.alsu_opcode    = r_pins[8:6];
  assign bus.alsu_cin       = r_pins[9];
  assign bus.alsu_serial_in = r_pins[10];
  assign bus.alsu_direction = r_pins[11];
  assign bus.alsu_red_op_A  = r_pins[12];
  assign bus.alsu_red_op_B  = r_pins[13];
  assign bus.alsu_bypass_A  = r_pins[14];
  assign bus.alsu_bypass_B  = r_pins[15];

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_out     = r_rsp_out;
  assign bus.rsp_invalid = r_rsp_invalid;
  assign bus.cmd_count   = r_cmd_count;
`ifdef ALSU_DRV_CHECK_EN
  assign bus.rsp_mismatch = r_rsp_mismatch;
`else
  assign bus.rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: pipelined ALSU model on the pins, directed + random commands, queue scoreboard.
module tb_alsu_cmd_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rdy_mode;      // 0 low, 1 high, 2 random
  bit   force_out;
  int   n_done;
  logic [7:0] exp_q[$]; // {mismatch, invalid, out}

  alsu_cmd_driver_if #(.CNT_W(16)) bus ();

  alsu_cmd_driver #(
    .LATENCY(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] w_pins = {bus.alsu_bypass_B, bus.alsu_bypass_A, bus.alsu_red_op_B, bus.alsu_red_op_A,
                        bus.alsu_direction, bus.alsu_serial_in, bus.alsu_cin,
                        bus.alsu_opcode, bus.alsu_B, bus.alsu_A};

  function automatic logic [15:0] mk(input int a, input int b, input int op, input bit cin,
                                     input bit sin, input bit dir, input bit ra, input bit rb,
                                     input bit ba, input bit bb);
    logic [2:0] a3, b3, o3;
    a3 = 3'(a); b3 = 3'(b); o3 = 3'(op);
    return {bb, ba, rb, ra, dir, sin, cin, o3, b3, a3};
  endfunction

  function automatic bit alsu_bad(input logic [15:0] p);
    int op;
    op = int'(p[8:6]);
    return (op >= 6) || ((p[12] || p[13]) && op >= 2);
  endfunction

  // ALSU combinational result (INPUT_PRIORITY=A, FULL_ADDER=ON) given its registered inputs.
  function automatic logic [5:0] alsu_calc(input logic [15:0] p, input logic [5:0] prev);
    logic [2:0] a, b;
    int op, r;
    a = p[2:0]; b = p[5:3]; op = int'(p[8:6]);
    if (p[14]) return {3'b0, a};
    if (p[15]) return {3'b0, b};
    if (alsu_bad(p)) return 6'd0;
    case (op)
      0: r = p[12] ? int'(&a) : (p[13] ? int'(&b) : int'(a & b));
      1: r = p[12] ? int'(^a) : (p[13] ? int'(^b) : int'(a ^ b));
      2: r = int'(a) + int'(b) + int'(p[9]);
      3: r = int'(a) * int'(b);
      4: r = p[11] ? int'({prev[4:0], p[10]}) : int'({p[10], prev[5:1]});
      default: r = p[11] ? int'({prev[4:0], prev[5]}) : int'({prev[0], prev[5:1]});
    endcase
    return 6'(r);
  endfunction

  // ALSU stand-in: input register stage then output register stage.
  logic [15:0] m_in;
  logic [5:0]  m_out;
  logic [15:0] m_leds;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in <= 16'h0; m_out <= 6'h0; m_leds <= 16'h0;
    end else begin
      m_in   <= w_pins;
      m_out  <= alsu_calc(m_in, m_out);
      m_leds <= alsu_bad(m_in) ? ~m_leds : 16'h0;
    end
  end
  assign bus.alsu_out  = force_out ? 6'h3F : m_out;
  assign bus.alsu_leds = m_leds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hard_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  always begin
    @(posedge clk);
    #1;
    bus.rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Monitor: every completed response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        hard_fail("unexpected_rsp");
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rsp_out", 32'(bus.rsp_out), 32'(e[5:0]));
        check("rsp_invalid", 32'(bus.rsp_invalid), 32'(e[6]));
        check("rsp_mismatch", 32'(bus.rsp_mismatch), 32'(e[7]));
        check("cmd_count", 32'(bus.cmd_count), 32'(16'(n_done)));
      end
      n_done++;
    end
  end

  // Present a command from posedge+1; returns 1ns after its accepting edge.
  task automatic send(input logic [15:0] d, input logic [5:0] eo, input bit ei,
                      input bit frc, input bit push);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 200) begin
        hard_fail("cmd_ready_timeout");
        break;
      end
    end
    force_out = frc;
    if (push) exp_q.push_back({frc, ei, eo});
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !bus.cmd_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        hard_fail("drain_timeout");
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [9:0]  snap;
    logic [15:0] cnt_snap;
    int n;
    checks = 0; errors = 0; n_done = 0;
    rdy_mode = 1; force_out = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = 16'h0; bus.rsp_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_pins", 32'(w_pins), 32'd0);
    check("rst_count", 32'(bus.cmd_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp", 32'({bus.rsp_out, bus.rsp_invalid, bus.rsp_mismatch}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Add with carry, plus exact response latency.
    send(mk(3, 5, 2, 1, 0, 0, 0, 0, 0, 0), 6'd9, 1'b0, 1'b0, 1'b1);
    check("drive_pins", 32'(w_pins), 32'(mk(3, 5, 2, 1, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_valid_low", 32'(bus.rsp_valid), 32'd0);
      check("busy_ready", 32'({bus.busy, bus.cmd_ready}), 32'b10);
    end
    @(negedge clk);
    check("lat_valid_high", 32'(bus.rsp_valid), 32'd1);

    send(mk(7, 7, 3, 0, 0, 0, 0, 0, 0, 0), 6'd49, 1'b0, 1'b0, 1'b1);
    send(mk(6, 3, 0, 0, 0, 0, 0, 0, 0, 0), 6'd2,  1'b0, 1'b0, 1'b1);
    send(mk(1, 2, 6, 0, 0, 0, 0, 0, 0, 0), 6'd0,  1'b1, 1'b0, 1'b1);
    send(mk(1, 2, 2, 0, 0, 0, 1, 0, 0, 0), 6'd0,  1'b1, 1'b0, 1'b1);
    send(mk(5, 1, 1, 0, 0, 0, 0, 0, 0, 0), 6'd4,  1'b0, 1'b0, 1'b1);
    send(mk(5, 2, 0, 0, 0, 0, 0, 0, 1, 1), 6'd5,  1'b0, 1'b0, 1'b1);
    send(mk(0, 0, 4, 0, 1, 0, 0, 0, 0, 0), 6'd32, 1'b0, 1'b0, 1'b1);
    send(mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0), 6'd1,  1'b0, 1'b0, 1'b1);
    send(mk(4, 6, 7, 0, 0, 0, 0, 0, 0, 1), 6'd6,  1'b1, 1'b0, 1'b1);

    // Consumer stall: response must hold still.
    wait_idle();
    rdy_mode = 0;
    @(posedge clk); #1;
    send(mk(2, 3, 3, 0, 0, 0, 0, 0, 0, 0), 6'd6, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.rsp_valid) hard_fail("stall_rsp_timeout");
    snap = {bus.rsp_valid, bus.rsp_out, bus.rsp_invalid, bus.rsp_mismatch, bus.cmd_ready};
    cnt_snap = bus.cmd_count;
    check("stall_first", 32'(snap), 32'({1'b1, 6'd6, 1'b0, 1'b0, 1'b0}));
    repeat (10) begin
      @(negedge clk);
      check("stall_hold", 32'({bus.rsp_valid, bus.rsp_out, bus.rsp_invalid, bus.rsp_mismatch,
                               bus.cmd_ready}), 32'(snap));
      check("stall_count", 32'(bus.cmd_count), 32'(cnt_snap));
    end
    rdy_mode = 1;
    wait_idle();

    // Reset while waiting on the ALSU drops the command.
    send(mk(7, 1, 2, 1, 0, 0, 0, 0, 0, 0), 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_pins", 32'(w_pins), 32'd0);
    check("rst_mid_state", 32'({bus.rsp_valid, bus.cmd_ready, bus.busy}), 32'b010);
    #1 rst = 1'b0;
    n_done = 0;
    repeat (8) @(negedge clk);
    check("rst_mid_count", 32'(bus.cmd_count), 32'd0);
    check("rst_mid_norsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;

`ifdef ALSU_DRV_CHECK_EN
    send(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 6'h3F, 1'b0, 1'b1, 1'b1);
    send(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 6'd1,  1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with a random consumer.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      bit frc;
      d = 16'($urandom);
      frc = 1'b0;
`ifdef ALSU_DRV_CHECK_EN
      frc = ($urandom_range(0, 7) == 0);
`endif
      send(d, alsu_calc(d, 6'd0), alsu_bad(d), frc, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    wait_idle();
    repeat (3) @(posedge clk);
    check("final_count", 32'(bus.cmd_count), 32'(16'(n_done)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
